// File: rtl/fp_add_align.sv
// fp_add_align: two-stage align-and-add front end feeding a downstream normaliser
module fp_add_align (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        a_sign,
  input  logic [6:0]  a_exponent,
  input  logic [16:0] a_mantissa,
  input  logic        b_sign,
  input  logic [6:0]  b_exponent,
  input  logic [16:0] b_mantissa,
  input  logic        op_sub,
  output logic        valid_out,
  output logic        out_sign,
  output logic [6:0]  out_exponent,
  output logic [17:0] out_mantissa
);
  logic        w_a_zero, w_b_zero, w_b_sign, w_a_big;
  logic [6:0]  w_a_exp, w_b_exp, w_d;
  logic [17:0] w_a_mag, w_b_mag, w_s_mag, w_s_al;
  logic [18:0] w_sum;
  logic        r1_valid, r1_sign, r1_sub;
  logic [6:0]  r1_exp;
  logic [17:0] r1_mag_l, r1_mag_s;

  // operand decode, larger-operand selection and alignment shift of the smaller one
  always_comb begin
    w_a_zero = a_exponent < 7'd16;
    w_b_zero = b_exponent < 7'd16;
    w_a_exp  = w_a_zero ? 7'd0 : a_exponent;
    w_b_exp  = w_b_zero ? 7'd0 : b_exponent;
    w_a_mag  = w_a_zero ? 18'd0 : {1'b1, a_mantissa};
    w_b_mag  = w_b_zero ? 18'd0 : {1'b1, b_mantissa};
    w_b_sign = b_sign ^ op_sub;
    w_a_big  = (w_a_exp > w_b_exp) || (w_a_exp == w_b_exp && w_a_mag >= w_b_mag);
    w_d      = w_a_big ? w_a_exp - w_b_exp : w_b_exp - w_a_exp;
    w_s_mag  = w_a_big ? w_b_mag : w_a_mag;
    w_s_al   = (w_d >= 7'd18) ? 18'd0 : w_s_mag >> w_d;
    w_sum    = r1_sub ? {1'b0, r1_mag_l} - {1'b0, r1_mag_s} : {1'b0, r1_mag_l} + {1'b0, r1_mag_s};
  end

  // stage 1: capture the larger operand and the aligned smaller magnitude
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r1_sign  <= 1'b0;
      r1_sub   <= 1'b0;
      r1_exp   <= 7'd0;
      r1_mag_l <= 18'd0;
      r1_mag_s <= 18'd0;
    end else begin
      r1_valid <= valid_in;
      if (valid_in) begin
        r1_sign  <= w_a_big ? a_sign : w_b_sign;
        r1_sub   <= a_sign ^ w_b_sign;
        r1_exp   <= w_a_big ? w_a_exp : w_b_exp;
        r1_mag_l <= w_a_big ? w_a_mag : w_b_mag;
        r1_mag_s <= w_s_al;
      end
    end
  end

  // stage 2: add or subtract magnitudes, rebias exponent, zero-clean the sign
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out    <= 1'b0;
      out_sign     <= 1'b0;
      out_exponent <= 7'd0;
      out_mantissa <= 18'd0;
    end else begin
      valid_out <= r1_valid;
      if (r1_valid) begin
        out_sign     <= (w_sum == 19'd0) ? 1'b0 : r1_sign;
        out_exponent <= (r1_exp == 7'd0) ? 7'd0 : r1_exp - 7'd16;
        out_mantissa <= w_sum[18:1];
      end
    end
  end
endmodule

// File: tb/tb_fp_add_align.sv
// tb_fp_add_align: directed-vector checks of the align/add pipeline
module tb_fp_add_align;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic        a_sign = 1'b0, b_sign = 1'b0, op_sub = 1'b0;
  logic [6:0]  a_exponent = 7'd0, b_exponent = 7'd0;
  logic [16:0] a_mantissa = 17'd0, b_mantissa = 17'd0;
  logic        valid_out, out_sign;
  logic [6:0]  out_exponent;
  logic [17:0] out_mantissa;
  int checks = 0;
  int errors = 0;

  fp_add_align dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .a_sign(a_sign), .a_exponent(a_exponent), .a_mantissa(a_mantissa),
    .b_sign(b_sign), .b_exponent(b_exponent), .b_mantissa(b_mantissa),
    .op_sub(op_sub), .valid_out(valid_out), .out_sign(out_sign),
    .out_exponent(out_exponent), .out_mantissa(out_mantissa)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic as, input logic [6:0] ae, input logic [16:0] am,
                       input logic bs, input logic [6:0] be, input logic [16:0] bm, input logic sub);
    valid_in = 1'b1; a_sign = as; a_exponent = ae; a_mantissa = am;
    b_sign = bs; b_exponent = be; b_mantissa = bm; op_sub = sub;
  endtask

  task automatic single(input logic as, input logic [6:0] ae, input logic [16:0] am,
                        input logic bs, input logic [6:0] be, input logic [16:0] bm, input logic sub);
    apply(as, ae, am, bs, be, bm, sub);
    tick();
    valid_in = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    apply(1'b0, 7'd63, 17'd0, 1'b0, 7'd63, 17'd0, 1'b0);
    tick(); tick(); tick();
    checks++;
    if ({valid_out, out_sign, out_exponent, out_mantissa} !== 27'd0) begin
      errors++;
      $display("FAIL reset_hold got v=%b s=%b e=%0d m=%h want all 0", valid_out, out_sign, out_exponent, out_mantissa);
    end
    valid_in = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add();
    single(1'b0, 7'd63, 17'h00000, 1'b0, 7'd63, 17'h00000, 1'b0);
    checks++;
    if ({valid_out, out_sign, out_exponent, out_mantissa} !== {1'b1, 1'b0, 7'd47, 18'h20000}) begin
      errors++;
      $display("FAIL add_1p1 got v=%b s=%b e=%0d m=%h want v=1 s=0 e=47 m=20000", valid_out, out_sign, out_exponent, out_mantissa);
    end
    single(1'b0, 7'd63, 17'h10000, 1'b0, 7'd62, 17'h00000, 1'b0);
    checks++;
    if ({valid_out, out_sign, out_exponent, out_mantissa} !== {1'b1, 1'b0, 7'd47, 18'h20000}) begin
      errors++;
      $display("FAIL add_1p5_0p5 got v=%b s=%b e=%0d m=%h want v=1 s=0 e=47 m=20000", valid_out, out_sign, out_exponent, out_mantissa);
    end
    single(1'b0, 7'd63, 17'h00000, 1'b1, 7'd64, 17'h00000, 1'b0);
    checks++;
    if ({valid_out, out_sign, out_exponent, out_mantissa} !== {1'b1, 1'b1, 7'd48, 18'h08000}) begin
      errors++;
      $display("FAIL add_1_m2 got v=%b s=%b e=%0d m=%h want v=1 s=1 e=48 m=08000", valid_out, out_sign, out_exponent, out_mantissa);
    end
    single(1'b0, 7'd127, 17'h00000, 1'b0, 7'd127, 17'h00000, 1'b0);
    checks++;
    if ({valid_out, out_sign, out_exponent, out_mantissa} !== {1'b1, 1'b0, 7'd111, 18'h20000}) begin
      errors++;
      $display("FAIL add_max_exp got v=%b s=%b e=%0d m=%h want v=1 s=0 e=111 m=20000", valid_out, out_sign, out_exponent, out_mantissa);
    end
  endtask

  task automatic test_sub();
    single(1'b0, 7'd63, 17'h00000, 1'b0, 7'd63, 17'h00000, 1'b1);
    checks++;
    if ({valid_out, out_sign, out_exponent, out_mantissa} !== {1'b1, 1'b0, 7'd47, 18'h00000}) begin
      errors++;
      $display("FAIL sub_1m1 got v=%b s=%b e=%0d m=%h want v=1 s=0 e=47 m=00000", valid_out, out_sign, out_exponent, out_mantissa);
    end
    single(1'b0, 7'd63, 17'h00000, 1'b0, 7'd63, 17'h10000, 1'b1);
    checks++;
    if ({valid_out, out_sign, out_exponent, out_mantissa} !== {1'b1, 1'b1, 7'd47, 18'h08000}) begin
      errors++;
      $display("FAIL sub_1m1p5 got v=%b s=%b e=%0d m=%h want v=1 s=1 e=47 m=08000", valid_out, out_sign, out_exponent, out_mantissa);
    end
    single(1'b1, 7'd63, 17'h00000, 1'b0, 7'd63, 17'h00000, 1'b0);
    checks++;
    if ({valid_out, out_sign, out_exponent, out_mantissa} !== {1'b1, 1'b0, 7'd47, 18'h00000}) begin
      errors++;
      $display("FAIL cancel_sign got v=%b s=%b e=%0d m=%h want v=1 s=0 e=47 m=00000", valid_out, out_sign, out_exponent, out_mantissa);
    end
  endtask

  task automatic test_align();
    single(1'b0, 7'd63, 17'h00000, 1'b0, 7'd40, 17'h1FFFF, 1'b0);
    checks++;
    if ({valid_out, out_sign, out_exponent, out_mantissa} !== {1'b1, 1'b0, 7'd47, 18'h10000}) begin
      errors++;
      $display("FAIL align_d23 got v=%b s=%b e=%0d m=%h want v=1 s=0 e=47 m=10000", valid_out, out_sign, out_exponent, out_mantissa);
    end
    single(1'b0, 7'd63, 17'h00000, 1'b0, 7'd46, 17'h00000, 1'b0);
    checks++;
    if ({valid_out, out_sign, out_exponent, out_mantissa} !== {1'b1, 1'b0, 7'd47, 18'h10000}) begin
      errors++;
      $display("FAIL align_d17 got v=%b s=%b e=%0d m=%h want v=1 s=0 e=47 m=10000", valid_out, out_sign, out_exponent, out_mantissa);
    end
    single(1'b0, 7'd63, 17'h00000, 1'b0, 7'd45, 17'h1FFFF, 1'b0);
    checks++;
    if ({valid_out, out_sign, out_exponent, out_mantissa} !== {1'b1, 1'b0, 7'd47, 18'h10000}) begin
      errors++;
      $display("FAIL align_d18 got v=%b s=%b e=%0d m=%h want v=1 s=0 e=47 m=10000", valid_out, out_sign, out_exponent, out_mantissa);
    end
  endtask

  task automatic test_zero();
    single(1'b0, 7'd15, 17'h1FFFF, 1'b0, 7'd63, 17'h00000, 1'b0);
    checks++;
    if ({valid_out, out_sign, out_exponent, out_mantissa} !== {1'b1, 1'b0, 7'd47, 18'h10000}) begin
      errors++;
      $display("FAIL zero_exp15 got v=%b s=%b e=%0d m=%h want v=1 s=0 e=47 m=10000", valid_out, out_sign, out_exponent, out_mantissa);
    end
    single(1'b1, 7'd15, 17'h12345, 1'b1, 7'd0, 17'h00001, 1'b0);
    checks++;
    if ({valid_out, out_sign, out_exponent, out_mantissa} !== {1'b1, 1'b0, 7'd0, 18'h00000}) begin
      errors++;
      $display("FAIL zero_both got v=%b s=%b e=%0d m=%h want v=1 s=0 e=0 m=00000", valid_out, out_sign, out_exponent, out_mantissa);
    end
    single(1'b0, 7'd16, 17'h00000, 1'b0, 7'd0, 17'h00000, 1'b0);
    checks++;
    if ({valid_out, out_sign, out_exponent, out_mantissa} !== {1'b1, 1'b0, 7'd0, 18'h10000}) begin
      errors++;
      $display("FAIL exp16_min got v=%b s=%b e=%0d m=%h want v=1 s=0 e=0 m=10000", valid_out, out_sign, out_exponent, out_mantissa);
    end
  endtask

  task automatic test_back_to_back();
    logic [25:0] exp_r [4];
    exp_r[0] = {1'b0, 7'd47, 18'h20000};
    exp_r[1] = {1'b1, 7'd48, 18'h08000};
    exp_r[2] = {1'b0, 7'd47, 18'h28000};
    exp_r[3] = {1'b0, 7'd47, 18'h10000};
    apply(1'b0, 7'd63, 17'h00000, 1'b0, 7'd63, 17'h00000, 1'b0);
    tick();
    apply(1'b0, 7'd63, 17'h00000, 1'b1, 7'd64, 17'h00000, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({valid_out, out_sign, out_exponent, out_mantissa} !== {1'b1, exp_r[i]}) begin
        errors++;
        $display("FAIL b2b_%0d got v=%b s=%b e=%0d m=%h want v=1 {s,e,m}=%h", i, valid_out, out_sign, out_exponent, out_mantissa, exp_r[i]);
      end
      if (i == 0) apply(1'b0, 7'd63, 17'h10000, 1'b0, 7'd63, 17'h00000, 1'b0);
      else if (i == 1) apply(1'b0, 7'd63, 17'h00000, 1'b0, 7'd40, 17'h00000, 1'b0);
      else valid_in = 1'b0;
      tick();
    end
    checks++;
    if ({valid_out, out_sign, out_exponent, out_mantissa} !== {1'b0, exp_r[3]}) begin
      errors++;
      $display("FAIL gap_hold got v=%b s=%b e=%0d m=%h want v=0 {s,e,m}=%h", valid_out, out_sign, out_exponent, out_mantissa, exp_r[3]);
    end
    apply(1'b0, 7'd63, 17'h00000, 1'b1, 7'd64, 17'h00000, 1'b0);
    tick();
    valid_in = 1'b0;
    checks++;
    if ({valid_out, out_sign, out_exponent, out_mantissa} !== {1'b0, exp_r[3]}) begin
      errors++;
      $display("FAIL gap_hold2 got v=%b s=%b e=%0d m=%h want v=0 {s,e,m}=%h", valid_out, out_sign, out_exponent, out_mantissa, exp_r[3]);
    end
    tick();
    checks++;
    if ({valid_out, out_sign, out_exponent, out_mantissa} !== {1'b1, exp_r[1]}) begin
      errors++;
      $display("FAIL gap_resume got v=%b s=%b e=%0d m=%h want v=1 {s,e,m}=%h", valid_out, out_sign, out_exponent, out_mantissa, exp_r[1]);
    end
    tick();
  endtask

  task automatic test_reset_flush();
    apply(1'b0, 7'd63, 17'h00000, 1'b0, 7'd63, 17'h00000, 1'b0);
    tick();
    valid_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({valid_out, out_sign, out_exponent, out_mantissa} !== 27'd0) begin
      errors++;
      $display("FAIL async_clear got v=%b s=%b e=%0d m=%h want all 0", valid_out, out_sign, out_exponent, out_mantissa);
    end
    rst = 1'b0;
    tick(); tick();
    checks++;
    if ({valid_out, out_sign, out_exponent, out_mantissa} !== 27'd0) begin
      errors++;
      $display("FAIL flush_in_flight got v=%b s=%b e=%0d m=%h want all 0", valid_out, out_sign, out_exponent, out_mantissa);
    end
    single(1'b0, 7'd63, 17'h10000, 1'b0, 7'd62, 17'h00000, 1'b0);
    checks++;
    if ({valid_out, out_sign, out_exponent, out_mantissa} !== {1'b1, 1'b0, 7'd47, 18'h20000}) begin
      errors++;
      $display("FAIL after_reset got v=%b s=%b e=%0d m=%h want v=1 s=0 e=47 m=20000", valid_out, out_sign, out_exponent, out_mantissa);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_align();
    test_zero();
    test_back_to_back();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
